// File: rtl/serial_add_sequencer_if.sv
// Operand/result handshake bundle for serial_add_sequencer.
// The master side supplies operands and accepts results; the slave side is the sequencer.
interface serial_add_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  modport master (
    output in_valid, op_a, op_b, op_cin, out_ready,
    input  in_ready, out_valid, result, carry_out
  );

  modport slave (
    input  in_valid, op_a, op_b, op_cin, out_ready,
    output in_ready, out_valid, result, carry_out
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder built around one external combinational full adder.
// Operands arrive over bus (valid/ready), are fed to the adder LSB first with the
// carry held in a register, and the sum/carry-out are returned over bus.
// Optional feature macro: SERIAL_ADD_TRIG_GUARD_EN -- limits consecutive
// {a,b,cin}==3'b101 vectors at the adder to TRIG_LIMIT by inserting 000 bubble cycles.
// The bus interface instance must be parameterised with the same WIDTH.
module serial_add_sequencer #(
  parameter int WIDTH      = 8,
  parameter int TRIG_LIMIT = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  serial_add_sequencer_if.slave  bus,
  output logic                   fa_a,
  output logic                   fa_b,
  output logic                   fa_cin,
  input  logic                   fa_sum,
  input  logic                   fa_cout,
  output logic [7:0]             guard_events
);

  localparam int             IW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]  LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [IW-1:0]    bit_idx;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             carry_out_q;
  logic             bubble;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = res_sh;
  assign bus.carry_out = carry_out_q;

`ifdef SERIAL_ADD_TRIG_GUARD_EN
  localparam logic [IW-1:0] TRIG_VAL = IW'(TRIG_LIMIT);

  logic [IW-1:0] run_cnt;
  logic [7:0]    guard_cnt;

  // A bubble replaces the next vector whenever it would extend a 101 run past the limit.
  assign bubble = (state == RUN) && a_sh[0] && !b_sh[0] && carry && (run_cnt == TRIG_VAL);

  // Track the length of the current run of 101 vectors actually driven to the adder.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cnt <= '0;
    end else if ({fa_a, fa_b, fa_cin} == 3'b101) begin
      run_cnt <= run_cnt + 1'b1;
    end else begin
      run_cnt <= '0;
    end
  end

  // Count inserted bubbles, saturating at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      guard_cnt <= 8'd0;
    end else if (bubble && (guard_cnt != 8'hFF)) begin
      guard_cnt <= guard_cnt + 8'd1;
    end
  end

  assign guard_events = guard_cnt;
`else
  assign bubble       = 1'b0;
  assign guard_events = 8'd0;
`endif

  // Adder inputs: current operand LSBs and held carry in RUN, quiet otherwise.
  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if ((state == RUN) && !bubble) begin
      fa_a   = a_sh[0];
      fa_b   = b_sh[0];
      fa_cin = carry;
    end
  end

  // Sequencer FSM: accept operands, capture one sum bit per cycle, hold result until taken.
  // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      res_sh      <= '0;
      carry       <= 1'b0;
      bit_idx     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh       <= bus.op_a;
            b_sh       <= bus.op_b;
            carry      <= bus.op_cin;
            bit_idx    <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (!bubble) begin
            res_sh  <= {fa_sum, res_sh[WIDTH-1:1]};
            carry   <= fa_cout;
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST) begin
              carry_out_q <= fa_cout;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
